// File: rtl/display_pkg.sv
// ----------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the 7-segment scan controller.
//   scan_state_t : scan FSM states (S_BLANK = all anodes off, S_DRIVE = one
//                  digit driven)
//   MAX_DIGITS   : widest display the controller can sequence
//   AN_ALL_OFF   : active-low anode pattern with every digit off
//   lz_suppress  : leading-zero test for one digit position
// ----------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_t;

    localparam int         MAX_DIGITS = 4;
    localparam logic [3:0] AN_ALL_OFF = 4'b1111;

    // True when `digit` is a leading zero: it is not the rightmost digit and
    // every nibble from `digit` up to the last scanned digit is zero.
    function automatic logic lz_suppress(
        input logic [15:0] value,
        input logic [1:0]  digit,
        input int          num_digits
    );
        logic upper_zero;
        upper_zero = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((i >= int'(digit)) && (i < num_digits) && (value[i*4 +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end else begin
                upper_zero = upper_zero;
            end
        end
        return (digit != 2'd0) && upper_zero;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// display_scan_ctrl_if
// Load handshake between the calculator core and the scan controller.
//   load_valid : core presents a new display value
//   load_ready : controller's pending buffer is empty
//   load_value : four BCD nibbles, nibble i = digit i (digit 0 rightmost)
// A transfer happens on a clock edge with load_valid && load_ready.
// Modports: master = calculator core, slave = display_scan_ctrl.
// ----------------------------------------------------------------------------
interface display_scan_ctrl_if;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_value;

    modport master (output load_valid, output load_value, input  load_ready);
    modport slave  (input  load_valid, input  load_value, output load_ready);
endinterface

// File: rtl/display_scan_ctrl_scan_timer.sv
// ----------------------------------------------------------------------------
// scan_timer
// Up-counter with a run-time terminal count. The owner selects `last` per
// state and feeds `tc` back into `clr`, so the count restarts from zero on
// every state change without ever relying on overflow.
//   clk, reset : clock, synchronous active-low reset
//   clr        : synchronous clear (count <- 0 at the next edge)
//   last       : terminal count value
//   count      : current count
//   tc         : count == last
// ----------------------------------------------------------------------------
module scan_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear or increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {WIDTH{1'b0}};
        end else begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == last);

endmodule

// File: rtl/display_scan_ctrl.sv
// ----------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexes up to four common-anode 7-segment digits. Each digit is
// preceded by an all-off dead time to suppress ghosting. New values arrive on
// a valid/ready handshake into a pending buffer and are copied to the displayed
// (shadow) value only at a frame boundary.
//
// Ports:
//   clk, reset  : clock, synchronous active-low reset
//   load_if     : slave side of the load handshake (display_scan_ctrl_if)
//   lz_en       : leading-zero blanking enable, used combinationally
//   brightness  : 4-bit duty setting (only with BRIGHTNESS_PWM_EN defined)
//   digit_code  : nibble of the selected digit, to the segment decoder
//   an          : active-low anode enables, at most one bit low
//   blank       : segments must be forced off
//   frame_done  : one-cycle pulse in the first cycle of each new frame
//
// Optional feature macro: BRIGHTNESS_PWM_EN. When defined, the anode is only
// on for the first ((brightness+1)*DWELL_CYCLES)>>4 cycles of each dwell.
// ----------------------------------------------------------------------------
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int DWELL_CYCLES = 500000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset,
    display_scan_ctrl_if.slave  load_if,
    input  logic                lz_en,
`ifdef BRIGHTNESS_PWM_EN
    input  logic [3:0]          brightness,
`endif
    output logic [3:0]          digit_code,
    output logic [3:0]          an,
    output logic                blank,
    output logic                frame_done
);

    localparam int              TIMER_MAX   = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int              TW          = $clog2(TIMER_MAX);
    localparam logic [TW-1:0]   DWELL_LAST  = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0]   BLANK_LAST  = TW'(BLANK_CYCLES - 1);
    localparam logic [1:0]      LAST_IDX    = 2'(NUM_DIGITS - 1);
    // Nibbles at or above NUM_DIGITS are dropped on load.
    localparam logic [15:0]     VALUE_MASK  = 16'((32'd1 << (4 * NUM_DIGITS)) - 32'd1);

    scan_state_t  state_q, state_d;
    logic [1:0]   idx_q, idx_d;
    logic [15:0]  shadow_q, shadow_d;
    logic [15:0]  pending_q, pending_d;
    logic         pending_full_q, pending_full_d;
    logic         frame_done_q, frame_done_d;

    logic [TW-1:0] timer_s;
    logic [TW-1:0] timer_last_s;
    logic          timer_tc_s;
    logic          transfer_s;
    logic          boundary_s;
    logic [36:0]   on_cycles_s;
    logic          drive_on_s;
    logic [3:0]    nibble_s;
    logic          suppress_s;

    // Terminal count follows the current state's duration.
    always_comb begin
        if (state_q == S_DRIVE) begin
            timer_last_s = DWELL_LAST;
        end else begin
            timer_last_s = BLANK_LAST;
        end
    end

    scan_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_tc_s),
        .last  (timer_last_s),
        .count (timer_s),
        .tc    (timer_tc_s)
    );

    assign transfer_s        = load_if.load_valid && !pending_full_q;
    assign boundary_s        = (state_q == S_DRIVE) && timer_tc_s && (idx_q == LAST_IDX);
    assign load_if.load_ready = !pending_full_q;
    assign frame_done        = frame_done_q;

    // Next-state logic for scan sequencing and value buffering.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        shadow_d       = shadow_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        frame_done_d   = boundary_s;

        case (state_q)
            S_BLANK: begin
                if (timer_tc_s) begin
                    state_d = S_DRIVE;
                end else begin
                    state_d = S_BLANK;
                end
            end
            S_DRIVE: begin
                if (timer_tc_s) begin
                    state_d = S_BLANK;
                    if (idx_q == LAST_IDX) begin
                        idx_d = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    state_d = S_DRIVE;
                end
            end
            default: begin
                state_d = S_BLANK;
                idx_d   = 2'd0;
            end
        endcase

        // A transfer needs an empty buffer, so it can never coincide with a
        // boundary that consumes a full one; a same-cycle transfer waits for
        // the next boundary.
        if (boundary_s && pending_full_q) begin
            shadow_d       = pending_q;
            pending_full_d = 1'b0;
        end else if (transfer_s) begin
            pending_d      = load_if.load_value & VALUE_MASK;
            pending_full_d = 1'b1;
        end else begin
            pending_full_d = pending_full_q;
        end
    end

    // State and data registers with synchronous reset; reset drops any pending value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_BLANK;
            idx_q          <= 2'd0;
            shadow_q       <= 16'h0000;
            pending_q      <= 16'h0000;
            pending_full_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            shadow_q       <= shadow_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            frame_done_q   <= frame_done_d;
        end
    end

    // Anode-on window within a dwell: the whole dwell, or a brightness fraction of it.
    always_comb begin
`ifdef BRIGHTNESS_PWM_EN
        on_cycles_s = ((37'(brightness) + 37'd1) * 37'(DWELL_CYCLES)) >> 4'd4;
`else
        on_cycles_s = 37'(DWELL_CYCLES);
`endif
        drive_on_s = (37'(timer_s) < on_cycles_s);
    end

    assign nibble_s   = shadow_q[{idx_q, 2'b00} +: 4];
    assign suppress_s = lz_en && lz_suppress(shadow_q, idx_q, NUM_DIGITS);

    // Output decode from registered state, index and shadow value.
    always_comb begin
        an         = AN_ALL_OFF;
        blank      = 1'b1;
        digit_code = 4'h0;
        if (state_q == S_DRIVE) begin
            digit_code = nibble_s;
            if (!suppress_s && drive_on_s) begin
                an    = ~(4'b0001 << idx_q);
                blank = 1'b0;
            end else begin
                an    = AN_ALL_OFF;
                blank = 1'b1;
            end
        end else begin
            an    = AN_ALL_OFF;
            blank = 1'b1;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_display_scan_ctrl
// Directed, table-driven bench for display_scan_ctrl with NUM_DIGITS=3,
// DWELL_CYCLES=4, BLANK_CYCLES=2 (18-cycle frame). Each table record holds
// inputs applied for a run of cycles and the outputs expected in every one
// of those cycles; a hand-written sequence covers reset in mid-frame.
// ----------------------------------------------------------------------------
module tb_display_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       lz_en;
    logic [3:0] digit_code;
    logic [3:0] an;
    logic       blank;
    logic       frame_done;
`ifdef BRIGHTNESS_PWM_EN
    logic [3:0] brightness = 4'd15;
`endif

    display_scan_ctrl_if lif ();

    display_scan_ctrl #(
        .NUM_DIGITS   (3),
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_if    (lif.slave),
        .lz_en      (lz_en),
`ifdef BRIGHTNESS_PWM_EN
        .brightness (brightness),
`endif
        .digit_code (digit_code),
        .an         (an),
        .blank      (blank),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cycles;
        logic        lv;
        logic [15:0] lval;
        logic        lz;
        logic [3:0]  an;
        logic        blank;
        logic [3:0]  dig;
        logic        ready;
        logic        fd;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void add(int cyc, logic lv, logic [15:0] lval, logic lz,
                                logic [3:0] a, logic bl, logic [3:0] dig,
                                logic rdy, logic fd);
        vecs.push_back('{cyc, lv, lval, lz, a, bl, dig, rdy, fd});
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got {an,blank,ready,fd,dig}=%h expected %h", name, act, exp);
        end
    endtask

    // Digit code only matters while the digit is lit.
    function automatic logic [10:0] pack(logic [3:0] a, logic bl, logic rdy, logic fd, logic [3:0] dig);
        return {a, bl, rdy, fd, (bl ? 4'h0 : dig)};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] act;
        int          n;
        bit          seen;

        // Frame 1: reset value, all zeros displayed, digits E/D/B.
        add(2, 1'b0, 16'h0000, 1'b0, 4'hF, 1'b1, 4'h0, 1'b1, 1'b0);
        add(4, 1'b0, 16'h0000, 1'b0, 4'hE, 1'b0, 4'h0, 1'b1, 1'b0);
        add(2, 1'b0, 16'h0000, 1'b0, 4'hF, 1'b1, 4'h0, 1'b1, 1'b0);
        add(4, 1'b0, 16'h0000, 1'b0, 4'hD, 1'b0, 4'h0, 1'b1, 1'b0);
        add(2, 1'b0, 16'h0000, 1'b0, 4'hF, 1'b1, 4'h0, 1'b1, 1'b0);
        add(4, 1'b0, 16'h0000, 1'b0, 4'hB, 1'b0, 4'h0, 1'b1, 1'b0);
        // Frame 2: load 0123 mid-frame, then a held-off 0456.
        add(1, 1'b0, 16'h0000, 1'b0, 4'hF, 1'b1, 4'h0, 1'b1, 1'b1);
        add(1, 1'b0, 16'h0000, 1'b0, 4'hF, 1'b1, 4'h0, 1'b1, 1'b0);
        add(1, 1'b1, 16'h0123, 1'b0, 4'hE, 1'b0, 4'h0, 1'b1, 1'b0);
        add(3, 1'b0, 16'h0000, 1'b0, 4'hE, 1'b0, 4'h0, 1'b0, 1'b0);
        add(2, 1'b0, 16'h0000, 1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        add(4, 1'b1, 16'h0456, 1'b0, 4'hD, 1'b0, 4'h0, 1'b0, 1'b0);
        add(2, 1'b1, 16'h0456, 1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        add(4, 1'b1, 16'h0456, 1'b0, 4'hB, 1'b0, 4'h0, 1'b0, 1'b0);
        // Frame 3: 0123 shown, 0456 accepted in the boundary's next cycle.
        add(1, 1'b1, 16'h0456, 1'b0, 4'hF, 1'b1, 4'h0, 1'b1, 1'b1);
        add(1, 1'b0, 16'h0000, 1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        add(4, 1'b0, 16'h0000, 1'b0, 4'hE, 1'b0, 4'h3, 1'b0, 1'b0);
        add(2, 1'b0, 16'h0000, 1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        add(4, 1'b0, 16'h0000, 1'b0, 4'hD, 1'b0, 4'h2, 1'b0, 1'b0);
        add(2, 1'b0, 16'h0000, 1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        add(4, 1'b0, 16'h0000, 1'b0, 4'hB, 1'b0, 4'h1, 1'b0, 1'b0);
        // Frame 4: 0456 shown, 0005 loaded.
        add(1, 1'b1, 16'h0005, 1'b0, 4'hF, 1'b1, 4'h0, 1'b1, 1'b1);
        add(1, 1'b0, 16'h0000, 1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        add(4, 1'b0, 16'h0000, 1'b0, 4'hE, 1'b0, 4'h6, 1'b0, 1'b0);
        add(2, 1'b0, 16'h0000, 1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        add(4, 1'b0, 16'h0000, 1'b0, 4'hD, 1'b0, 4'h5, 1'b0, 1'b0);
        add(2, 1'b0, 16'h0000, 1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        add(4, 1'b0, 16'h0000, 1'b0, 4'hB, 1'b0, 4'h4, 1'b0, 1'b0);
        // Frame 5: 0005 with lz_en, digits 1 and 2 suppressed; 0000 loaded.
        add(1, 1'b1, 16'h0000, 1'b1, 4'hF, 1'b1, 4'h0, 1'b1, 1'b1);
        add(1, 1'b0, 16'h0000, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        add(4, 1'b0, 16'h0000, 1'b1, 4'hE, 1'b0, 4'h5, 1'b0, 1'b0);
        add(2, 1'b0, 16'h0000, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        add(4, 1'b0, 16'h0000, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        add(2, 1'b0, 16'h0000, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        add(4, 1'b0, 16'h0000, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        // Frame 6: 0000 with lz_en, digit 0 still lit showing 0; 0105 loaded.
        add(1, 1'b1, 16'h0105, 1'b1, 4'hF, 1'b1, 4'h0, 1'b1, 1'b1);
        add(1, 1'b0, 16'h0000, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        add(4, 1'b0, 16'h0000, 1'b1, 4'hE, 1'b0, 4'h0, 1'b0, 1'b0);
        add(2, 1'b0, 16'h0000, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        add(4, 1'b0, 16'h0000, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        add(2, 1'b0, 16'h0000, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        add(4, 1'b0, 16'h0000, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        // Frame 7: 0105 with lz_en, embedded zero in digit 1 stays lit.
        add(1, 1'b0, 16'h0000, 1'b1, 4'hF, 1'b1, 4'h0, 1'b1, 1'b1);
        add(1, 1'b0, 16'h0000, 1'b1, 4'hF, 1'b1, 4'h0, 1'b1, 1'b0);
        add(4, 1'b0, 16'h0000, 1'b1, 4'hE, 1'b0, 4'h5, 1'b1, 1'b0);
        add(2, 1'b0, 16'h0000, 1'b1, 4'hF, 1'b1, 4'h0, 1'b1, 1'b0);
        add(4, 1'b0, 16'h0000, 1'b1, 4'hD, 1'b0, 4'h0, 1'b1, 1'b0);
        add(2, 1'b0, 16'h0000, 1'b1, 4'hF, 1'b1, 4'h0, 1'b1, 1'b0);
        add(4, 1'b0, 16'h0000, 1'b1, 4'hB, 1'b0, 4'h1, 1'b1, 1'b0);

        reset          = 1'b0;
        lz_en          = 1'b0;
        lif.load_valid = 1'b0;
        lif.load_value = 16'h0000;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        for (int s = 0; s < vecs.size(); s++) begin
            lif.load_valid = vecs[s].lv;
            lif.load_value = vecs[s].lval;
            lz_en          = vecs[s].lz;
            for (int c = 0; c < vecs[s].cycles; c++) begin
                @(negedge clk);
                act = pack(an, blank, lif.load_ready, frame_done, digit_code);
                check($sformatf("vec%0d.c%0d", s, c), act,
                      pack(vecs[s].an, vecs[s].blank, vecs[s].ready, vecs[s].fd, vecs[s].dig));
                @(posedge clk);
                #1;
            end
        end

        // Reset during digit-1 drive with a pending value.
        lif.load_valid = 1'b1;
        lif.load_value = 16'h0987;
        @(posedge clk);
        #1 lif.load_valid = 1'b0;
        @(negedge clk);
        check("pend_full", {7'd0, lif.load_ready, 3'd0}, 11'd0);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (an == 4'b1101) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check("wait_d1", {10'd0, seen}, 11'd1);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        act = pack(an, blank, lif.load_ready, frame_done, digit_code);
        check("rst_mid", act, pack(4'hF, 1'b1, 1'b1, 1'b0, 4'h0));

        // Next frame_done should come one full frame (18 cycles) later.
        n    = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (n == 2) begin
                act = pack(an, blank, lif.load_ready, frame_done, digit_code);
                check("rst_d0", act, pack(4'hE, 1'b0, 1'b1, 1'b0, 4'h0));
            end
            seen = frame_done;
        end
        check("rst_frame", {1'b0, 10'(n)}, 11'd18);

        // Pending value was discarded: digit 0 still shows 0, buffer empty.
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        act = pack(an, blank, lif.load_ready, frame_done, digit_code);
        check("rst_discard", act, pack(4'hE, 1'b0, 1'b1, 1'b0, 4'h0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing controller for the calculator's 7-segment display. It sequences up to four common-anode digits with a dead-time interval between digits to suppress ghosting. It accepts new BCD values from the calculator core through a valid/ready handshake and double-buffers them so a value change takes effect only at a frame boundary. It blanks leading zeros on request. Its outputs drive the anode pins directly, and its digit code feeds the existing seven-segment decoder.

## Interface
- NUM_DIGITS, 3: digits scanned, 1..4; digit 0 is the rightmost digit.
- DWELL_CYCLES, 500000: clocks each digit is driven, at least 2.
- BLANK_CYCLES, 1000: clocks all anodes are off between digits, at least 1.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- load_valid  in  1  core presents a new display value.
- load_ready  out  1  pending buffer empty; a transfer occurs on `load_valid && load_ready`.
- load_value  in  16  four BCD nibbles; nibble i = digit i; nibbles at or above NUM_DIGITS are ignored.
- lz_en  in  1  leading-zero blanking enable; sampled every cycle.
- digit_code  out  4  nibble of the currently selected digit, passed to the segment decoder.
- an  out  4  active-low anode enables; at most one bit is low.
- blank  out  1  high when the segment outputs must be forced off.
- frame_done  out  1  one-cycle pulse at the start of each new frame.

## Operation
- State register `state` has two states, S_BLANK and S_DRIVE. Supporting registers:
  - digit index `idx`
  - cycle counter `timer`
  - `shadow` (16 bits, the displayed value)
  - `pending` (16 bits) and `pending_full`
- Reset (reset=0 at a clk edge):
  - state=S_BLANK, idx=0, timer=0
  - shadow=0, pending=0, pending_full=0
  - frame_done=0
  - Outputs then read an=4'b1111, blank=1, digit_code=0, load_ready=1.
  - Reset asserted mid-frame aborts the frame immediately. A pending value is discarded.
- S_BLANK:
  - an=4'b1111, blank=1.
  - When timer==BLANK_CYCLES-1: timer←0, go to S_DRIVE.
- S_DRIVE:
  - digit_code=shadow[idx].
  - an has bit idx low, unless the digit is suppressed. A suppressed digit gives an=4'b1111, blank=1.
  - When timer==DWELL_CYCLES-1: timer←0, go to S_BLANK.
    - If idx==NUM_DIGITS-1: idx←0 (frame boundary).
    - Otherwise: idx←idx+1.
- Frame boundary:
  - If pending_full: shadow←pending, pending_full←0.
  - frame_done is registered high for exactly one cycle, the first cycle of the next S_BLANK.
- Handshake:
  - load_ready = !pending_full.
  - A transfer sets pending←load_value and pending_full←1.
  - A transfer and a frame boundary in the same cycle: the boundary copies the old pending only if it was full. Since load_ready=1 means pending was empty, the new value stays in pending until the next boundary.
  - load_valid while load_ready=0 is held off. No data is lost, and pending is not overwritten.
- Leading-zero suppression:
  - Digit i (i≥1) is suppressed when lz_en=1 and shadow nibbles i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never suppressed.
- Nibbles 10..15 are passed through unmodified. The segment decoder owns their glyphs.

## Timing
- an, blank and digit_code are combinational decodes of registered state, idx and shadow. They change in the cycle after the controlling clock edge.
- Digit period = BLANK_CYCLES + DWELL_CYCLES.
- Frame period = NUM_DIGITS × (BLANK_CYCLES + DWELL_CYCLES).
- Load-to-display latency is one boundary after acceptance: at most one frame period plus one cycle.
- timer width = $clog2(max(DWELL_CYCLES, BLANK_CYCLES)). timer wraps only through the terminal-count compare, never by overflow.

## Configuration
- BRIGHTNESS_PWM_EN:
  - Defined: adds input `brightness` (4 bits). In S_DRIVE, the anode stays low only while timer < ((brightness+1)×DWELL_CYCLES)>>4. The anode is off for the remainder of the dwell, with blank=1 during that remainder.
  - The sequencing, the frame period and the handshake are unchanged.
  - brightness=15 gives the full dwell.
  - Undefined: no port; the anode is low for the full dwell.

## Structure
- Package `display_pkg` holds:
  - `scan_state_t` (S_BLANK, S_DRIVE)
  - `MAX_DIGITS`=4
  - `AN_ALL_OFF`=4'b1111
- Sub-module `scan_timer`: a parameterised terminal-count counter with a synchronous clear and a `tc` output. It is instantiated once and reloaded per state.

## Test plan
Use NUM_DIGITS=3, DWELL_CYCLES=4, BLANK_CYCLES=2.
- Reset released: an=1111 for 2 cycles, then 1110 for 4, 1111 for 2, 1101 for 4, 1111 for 2, 1011 for 4; frame_done pulses every 18 cycles.
- Load 16'h0123 mid-frame: load_ready drops for that frame. digit_code shows 0 until the boundary, then 3,2,1. load_ready returns to 1 the cycle after the boundary.
- A second load_valid while pending_full: no transfer; pending holds the first value; the second value is accepted after the boundary.
- lz_en=1 with value 0x0005: digits 1 and 2 give an=1111 and blank=1; digit 0 shows 5. With value 0x0000, digit 0 still shows 0.
- reset pulsed low during S_DRIVE of digit 1 with pending_full=1: the next cycle gives an=1111, idx=0, load_ready=1, and shadow=0.
- With BRIGHTNESS_PWM_EN, brightness=7: the anode is low for the first 2 of the 4 dwell cycles; the frame period stays 18.
